// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: prescale encodings, frame bit indices and small helpers
// used by the sampler and the parity/start/stop checkers.
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W = 6;
    localparam int unsigned BIT_IDX_W  = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    localparam logic [BIT_IDX_W-1:0] BIT_START      = 4'd0;
    localparam logic [BIT_IDX_W-1:0] BIT_DATA_FIRST = 4'd1;
    localparam logic [BIT_IDX_W-1:0] BIT_DATA_LAST  = 4'd8;
    localparam logic [BIT_IDX_W-1:0] BIT_PARITY     = 4'd9;

    // Stop bit follows the parity bit when present, else the last data bit.
    function automatic logic [BIT_IDX_W-1:0] stop_bit_idx(input logic par_en);
        return par_en ? BIT_PARITY + 4'd1 : BIT_DATA_LAST + 4'd1;
    endfunction

    function automatic logic is_data_bit(input logic [BIT_IDX_W-1:0] idx);
        return (idx >= BIT_DATA_FIRST) && (idx <= BIT_DATA_LAST);
    endfunction

    function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] ps);
        return (ps == PRESCALE_8) || (ps == PRESCALE_16) || (ps == PRESCALE_32);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_majority_vote.sv
// Captures two samples just before mid-bit and votes them against the live sample
// to produce the bit value and its one-cycle valid strobe.
module rx_majority_vote
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    input  logic i_cap0,
    input  logic i_cap1,
    input  logic i_vote,
    output logic o_bit,
    output logic o_valid
);

    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
            o_bit   <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            if (i_cap0) r_s0 <= i_rx;
            if (i_cap1) r_s1 <= i_rx;
            if (i_vote) o_bit <= majority3(r_s0, r_s1, i_rx);
            o_valid <= i_vote;
        end
    end

endmodule

// File: rtl/rx_edge_bit_sampler.sv
// UART RX timing stage: synchronizes RX_IN, tracks edge/bit position within a frame
// and produces a majority-voted sample of each bit around its midpoint.
module rx_edge_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_IDX_W-1:0]  bit_count,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  frame_done,
    output logic                  cfg_err
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    // Synchronizer: r_sync[0] takes the raw line, MSB is the clean sample.
    if (SYNC_STAGES > 1) begin : g_sync_chain
        always_ff @(posedge clk) begin
            if (rst) r_sync <= '1;
            else     r_sync <= {r_sync[SYNC_STAGES-2:0], RX_IN};
        end
    end else begin : g_sync_single
        always_ff @(posedge clk) begin
            if (rst) r_sync <= '1;
            else     r_sync <= RX_IN;
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    logic                  r_en_d;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  w_en_rise;
    logic                  w_counting;
    logic [PRESCALE_W-1:0] w_half;
    logic                  w_last_edge;
    logic                  w_last_bit;
    logic [PRESCALE_W-1:0] w_edge_nxt;
    logic [BIT_IDX_W-1:0]  w_bit_nxt;
    logic                  w_frame_done_nxt;

    assign w_en_rise   = enable & ~r_en_d;
    assign w_counting  = enable & ~w_en_rise & ~cfg_err;
    assign w_half      = r_prescale >> 1;
    assign w_last_edge = (edge_count == (r_prescale - 6'd1));
    assign w_last_bit  = (bit_count >= stop_bit_idx(par_en));

    // Counter next state; anything other than active counting returns to 0/0.
    always_comb begin
        w_edge_nxt       = '0;
        w_bit_nxt        = BIT_START;
        w_frame_done_nxt = 1'b0;
        if (w_counting) begin
            if (w_last_edge) begin
                if (!w_last_bit) w_bit_nxt = bit_count + 4'd1;
            end else begin
                w_edge_nxt = edge_count + 6'd1;
                w_bit_nxt  = bit_count;
            end
            // Pulse is visible together with the final edge of the stop bit.
            w_frame_done_nxt = w_last_bit && !w_last_edge &&
                               (edge_count == (r_prescale - 6'd2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_d     <= 1'b0;
            r_prescale <= PRESCALE_8;
            cfg_err    <= 1'b0;
            edge_count <= '0;
            bit_count  <= BIT_START;
            frame_done <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (w_en_rise) begin
                r_prescale <= prescale;
                cfg_err    <= ~prescale_legal(prescale);
            end
            edge_count <= w_edge_nxt;
            bit_count  <= w_bit_nxt;
            frame_done <= w_frame_done_nxt;
        end
    end

    rx_majority_vote u_vote (
        .clk     (clk),
        .rst     (rst),
        .i_rx    (w_rx_s),
        .i_cap0  (w_counting && (edge_count == (w_half - 6'd1))),
        .i_cap1  (w_counting && (edge_count == w_half)),
        .i_vote  (w_counting && (edge_count == (w_half + 6'd1))),
        .o_bit   (sampled_bit),
        .o_valid (sample_valid)
    );

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Self-checking bench for rx_edge_bit_sampler: table of frames with a sampled-bit
// scoreboard, plus hand sequences for abort, reset and illegal prescale.
module tb_rx_edge_bit_sampler;
    import uart_rx_pkg::*;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       enable;
    logic [5:0] prescale;
    logic       par_en;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       sample_valid;
    logic       frame_done;
    logic       cfg_err;

    always #5 clk = ~clk;

    rx_edge_bit_sampler #(.SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .enable       (enable),
        .prescale     (prescale),
        .par_en       (par_en),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    typedef struct {
        logic [5:0] ps;
        logic       pe;
        logic [7:0] data;
        logic       par;
        int         gl_bit;   // bit whose mid samples get flipped, -1 for none
        logic [2:0] gl_mask;  // flip at h-1 / h / h+1
        logic       gl_exp;   // expected vote for the glitched bit
    } vec_t;

    vec_t vecs[5];
    vec_t cur;
    int   n_chk;
    int   n_fail;
    logic exp_q[$];
    int   gpos;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int last_idx();
        return cur.pe ? 10 : 9;
    endfunction

    function automatic int total();
        return (last_idx() + 1) * int'(cur.ps);
    endfunction

    // Desired synchronized line level at global frame position g.
    function automatic logic lvl(input int g);
        int         p;
        int         b;
        int         e;
        int         h;
        logic [10:0] f;
        logic       v;
        p = int'(cur.ps);
        h = p / 2;
        if (g < 0) return 1'b1;
        b = g / p;
        e = g % p;
        if (b > last_idx()) return 1'b1;
        f = cur.pe ? {1'b1, cur.par, cur.data, 1'b0} : {2'b11, cur.data, 1'b0};
        v = f[b];
        if (b == cur.gl_bit) begin
            for (int k = 0; k < 3; k++)
                if (cur.gl_mask[k] && (e == h - 1 + k)) v = ~v;
        end
        return v;
    endfunction

    function automatic logic exp_bit(input int b);
        if (b == cur.gl_bit) return cur.gl_exp;
        return lvl(b * int'(cur.ps));
    endfunction

    task automatic start_frame(input int idx);
        cur    = vecs[idx];
        enable = 1'b0;
        RX_IN  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        prescale = cur.ps;
        par_en   = cur.pe;
        RX_IN    = lvl(S - 1);
        enable   = 1'b1;
        exp_q.delete();
        gpos = 0;
    endtask

    // Each cycle shows position gpos; RX_IN is driven S positions ahead of it.
    task automatic step_frame(input int n);
        for (int i = 0; i < n; i++) begin
            int p;
            int h;
            int g;
            @(posedge clk);
            #1;
            p = int'(cur.ps);
            h = p / 2;
            g = gpos;
            if (g % p == 0) exp_q.push_back(exp_bit(g / p));
            check("edge_count", int'(edge_count), g % p);
            check("bit_count", int'(bit_count), g / p);
            check("sample_valid", int'(sample_valid), int'(g % p == h + 2));
            check("frame_done", int'(frame_done), int'(g == total() - 1));
            if (sample_valid) begin
                check("sb_depth_at_valid", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("sampled_bit", int'(sampled_bit), int'(exp_q.pop_front()));
            end
            RX_IN = lvl(g + S);
            gpos++;
        end
    endtask

    initial begin
        int fd_cnt;
        int stuck;

        n_chk  = 0;
        n_fail = 0;
        vecs[0] = '{6'd8,  1'b1, 8'hA5, 1'b0, -1, 3'b000, 1'b0};
        vecs[1] = '{6'd16, 1'b0, 8'hFF, 1'b0,  1, 3'b010, 1'b1};
        vecs[2] = '{6'd16, 1'b0, 8'hFF, 1'b0,  1, 3'b011, 1'b0};
        vecs[3] = '{6'd32, 1'b0, 8'h3C, 1'b0, -1, 3'b000, 1'b0};
        vecs[4] = '{6'd8,  1'b0, 8'h81, 1'b0,  9, 3'b100, 1'b1};

        rst      = 1'b1;
        enable   = 1'b0;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_edge_count", int'(edge_count), 0);
        check("rst_bit_count", int'(bit_count), 0);
        check("rst_sampled_bit", int'(sampled_bit), 1);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        rst = 1'b0;

        // Full frames from the vector table.
        for (int v = 0; v < 5; v++) begin
            start_frame(v);
            step_frame(total());
            @(posedge clk);
            #1;
            check("wrap_edge_count", int'(edge_count), 0);
            check("wrap_bit_count", int'(bit_count), 0);
            check("wrap_frame_done", int'(frame_done), 0);
            check("sb_drained", exp_q.size(), 0);
        end

        // Abort at bit 5 with prescale 32: no frame_done afterwards.
        start_frame(3);
        step_frame(5 * 32 + 10);
        enable = 1'b0;
        fd_cnt = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            fd_cnt += int'(frame_done);
        end
        check("abort_frame_done_count", fd_cnt, 0);
        check("abort_edge_count", int'(edge_count), 0);
        check("abort_bit_count", int'(bit_count), 0);

        // Drop enable at bit 4 / edge 3.
        start_frame(0);
        step_frame(4 * 8 + 3 + 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("drop_edge_count", int'(edge_count), 0);
        check("drop_bit_count", int'(bit_count), 0);
        check("drop_sample_valid", int'(sample_valid), 0);
        check("drop_sampled_bit", int'(sampled_bit), int'(exp_bit(3)));
        check("drop_frame_done", int'(frame_done), 0);

        // Reset mid-frame at bit 6 with enable still high, then restart.
        start_frame(0);
        step_frame(6 * 8 + 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_edge_count", int'(edge_count), 0);
        check("midrst_bit_count", int'(bit_count), 0);
        check("midrst_sampled_bit", int'(sampled_bit), 1);
        check("midrst_sample_valid", int'(sample_valid), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_cfg_err", int'(cfg_err), 0);
        rst = 1'b0;
        start_frame(0);
        step_frame(total());

        // Illegal prescale latch, ignored change while enabled, then legal relatch.
        enable = 1'b0;
        RX_IN  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        prescale = 6'd12;
        par_en   = 1'b0;
        enable   = 1'b1;
        @(posedge clk);
        #1;
        check("cfg_err_set", int'(cfg_err), 1);
        check("cfg_edge_count", int'(edge_count), 0);
        check("cfg_bit_count", int'(bit_count), 0);
        prescale = 6'd16;
        stuck = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (edge_count != 6'd0 || bit_count != 4'd0 || cfg_err != 1'b1 || sample_valid)
                stuck++;
        end
        check("cfg_err_hold_cycles", stuck, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("cfg_err_held_while_idle", int'(cfg_err), 1);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("cfg_err_cleared", int'(cfg_err), 0);
        check("relatch_edge_count", int'(edge_count), 0);
        repeat (4) @(posedge clk);
        #1;
        check("relatch_counting", int'(edge_count), 4);
        enable = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_edge_bit_sampler.md
Name: rx_edge_bit_sampler

Overview:
UART RX timing and sampling stage, directly upstream of the parity, start and stop check stages.
- Counts oversampling edges and bit positions within a frame.
- Takes three samples around mid-bit and produces a majority-voted `sampled_bit`.
- The RX FSM drives `enable`. Checkers consume `edge_count`, `bit_count` and `sampled_bit`.

Parameters:
SYNC_STAGES, 2, number of flops in the RX_IN synchronizer (range 1..3)

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  reset, synchronous, active-high
RX_IN  input  1  serial line, idles high, asynchronous to clk
enable  input  1  from RX FSM; high while a frame is being received
prescale  input  6  oversampling ratio; legal values 8, 16, 32
par_en  input  1  frame includes a parity bit
edge_count  output  6  edge position within the current bit, 0..prescale-1
bit_count  output  4  bit position: 0 start, 1..8 data, 9 parity (if par_en), last = stop
sampled_bit  output  1  majority-voted value of the current bit
sample_valid  output  1  1-cycle pulse: sampled_bit updated this cycle
frame_done  output  1  1-cycle pulse at the last edge of the stop bit
cfg_err  output  1  latched prescale is illegal

Behaviour:
- Reset (rst=1 at posedge):
  - edge_count=0, bit_count=0, sampled_bit=1, sample_valid=0, frame_done=0, cfg_err=0.
  - Synchronizer flops = 1, vote registers = 1.
- RX_IN passes through SYNC_STAGES flops. rx_s denotes the synchronizer output. All sampling uses rx_s.
- Prescale latching:
  - Prescale is latched on the first cycle `enable` is high after being low (rising edge of enable).
  - Changes to prescale while enable stays high are ignored.
- Illegal latched prescale (anything other than 8, 16, 32):
  - cfg_err=1 and the counters hold at 0.
  - cfg_err clears on the next legal latch or on rst.
- Midpoint: h = latched_prescale >> 1, computed in 6 bits.
- Edge counter, while enable=1:
  - edge_count increments each cycle.
  - When edge_count==prescale-1 it wraps to 0 and bit_count increments.
- Last bit index: L = 10 if par_en, else 9.
  - At bit_count==L with edge_count==prescale-1: frame_done=1 for one cycle, edge_count and bit_count return to 0.
- enable=0:
  - edge_count and bit_count are forced to 0 on the next posedge; sample_valid=0.
  - sampled_bit holds its last value.
  - Dropping enable mid-frame aborts the frame silently; frame_done is not asserted.
- Sampling:
  - s0 <= rx_s when edge_count==h-1.
  - s1 <= rx_s when edge_count==h.
  - When edge_count==h+1: sampled_bit <= majority(s0, s1, rx_s), and sample_valid <= 1 on the same edge.
  - The new sampled_bit is therefore visible and stable while edge_count==h+2. Downstream checkers compare at exactly h+2.
- Simultaneous events:
  - rst dominates enable.
  - Rising edge of enable with rst=0: the latch and edge_count=0 happen in the same cycle; counting starts on the following cycle.
- Widths:
  - Comparisons use 6-bit arithmetic.
  - h+1 never overflows for legal prescale.
  - bit_count saturates at L and never exceeds 10.

Decomposition:
- Shared package `uart_rx_pkg` holds:
  - PRESCALE_8/16/32 constants.
  - BIT_START=0, BIT_DATA_FIRST=1, BIT_DATA_LAST=8, BIT_PARITY=9.
  - Stop-bit index helpers, reused by the parity, start and stop checkers.
- One natural sub-module: `rx_majority_vote`, holding the s0/s1 registers and the 3-input majority.
- Edge and bit counters stay in the top block.

Test Plan:
1. prescale=8, par_en=1, frame 0x A5 (LSB first) with even parity bit 0 and stop 1, enable high for 88 cycles:
   - sampled_bit at each edge_count==6 reads 0, 1,0,1,0,0,1,0,1, 0, 1.
   - frame_done pulses once, at bit_count=10 / edge_count=7.
2. prescale=16, one bit=1 with rx_s forced low only at edge h (8):
   - sampled_bit=1.
   - With rx_s low at edges 7 and 8: sampled_bit=0.
   - sample_valid pulses once per bit.
3. prescale=32, par_en=0, full frame:
   - bit_count sequence 0..9.
   - Wrap to 0/0 after the edge_count==31 of bit 9.
   - No frame_done when enable drops at bit 5.
4. enable drops at bit_count=4 / edge_count=3:
   - Next cycle edge_count=0, bit_count=0, sample_valid=0, sampled_bit unchanged, frame_done=0.
5. rst=1 asserted mid-frame at bit 6:
   - Next posedge all outputs take their reset values.
   - Re-enable with prescale=8 restarts counting from 0/0.
6. enable rising with prescale=12:
   - cfg_err=1, counters stuck at 0.
   - Changing prescale to 16 while enable stays high has no effect.
   - Toggling enable low then high with prescale=16 clears cfg_err and starts counting.
